// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY transmit definitions: symbol codes, scheduler state and ts_sel encodings.
package pcie_phy_pkg;

  localparam int unsigned SYM_W   = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SKP_LEN = 4;
  localparam int unsigned TS_LEN  = 16;

  localparam logic [SYM_W-1:0] SYM_COM     = 8'hBC;
  localparam logic [SYM_W-1:0] SYM_SKP     = 8'h1C;
  localparam logic [SYM_W-1:0] SYM_PAD     = 8'hF7;
  localparam logic [SYM_W-1:0] SYM_TS1_ID  = 8'h4A;
  localparam logic [SYM_W-1:0] SYM_TS2_ID  = 8'h45;
  localparam logic [SYM_W-1:0] SYM_IDLE    = 8'h00;
  localparam logic [SYM_W-1:0] SYM_TS_CTRL = 8'h00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_SKP  = 2'd2;
  localparam logic [1:0] ST_TS   = 2'd3;

  localparam logic [1:0] TS_SEL_NONE = 2'b00;
  localparam logic [1:0] TS_SEL_TS1  = 2'b01;
  localparam logic [1:0] TS_SEL_TS2  = 2'b10;

  typedef enum logic [1:0] {
    OS_SKP = 2'd0,
    OS_TS1 = 2'd1,
    OS_TS2 = 2'd2
  } os_type_e;

  typedef struct packed {
    logic             k;
    logic [SYM_W-1:0] data;
  } tx_sym_t;

  // 2'b11 is reserved and behaves like "no training set"
  function automatic logic ts_sel_active(input logic [1:0] sel);
    return (sel == TS_SEL_TS1) || (sel == TS_SEL_TS2);
  endfunction

endpackage

// File: rtl/tx_symbol_scheduler_if.sv
// Link-layer to scheduler symbol handshake.
interface tx_symbol_scheduler_if;
  import pcie_phy_pkg::*;

  logic [SYM_W-1:0] tx_data;
  logic             tx_datak;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_datak, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_datak, input  tx_valid, output tx_ready);
endinterface

// File: rtl/tx_os_rom.sv
// Combinational ordered-set symbol table: (set type, symbol index) -> {K flag, symbol}.
module tx_os_rom
  import pcie_phy_pkg::*;
#(
  parameter logic [SYM_W-1:0] N_FTS   = 8'h20,
  parameter logic [SYM_W-1:0] RATE_ID = 8'h02
) (
  input  os_type_e         os_type,
  input  logic [IDX_W-1:0] idx,
  output tx_sym_t          sym_c
);

  always_comb begin
    sym_c = '{k: 1'b0, data: SYM_IDLE};
    if (os_type == OS_SKP) begin
      sym_c = '{k: 1'b1, data: (idx == '0) ? SYM_COM : SYM_SKP};
    end else begin
      case (idx)
        4'd0:       sym_c = '{k: 1'b1, data: SYM_COM};
        4'd1, 4'd2: sym_c = '{k: 1'b1, data: SYM_PAD};
        4'd3:       sym_c = '{k: 1'b0, data: N_FTS};
        4'd4:       sym_c = '{k: 1'b0, data: RATE_ID};
        4'd5:       sym_c = '{k: 1'b0, data: SYM_TS_CTRL};
        default:    sym_c = '{k: 1'b0, data: (os_type == OS_TS2) ? SYM_TS2_ID : SYM_TS1_ID};
      endcase
    end
  end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Per-lane transmit scheduler in front of the 8b/10b encoder: picks data, idle, SKP or TS1/TS2
// symbols each lane cycle and closes the running-disparity loop through the encoder.
module tx_symbol_scheduler
  import pcie_phy_pkg::*;
#(
  parameter int unsigned      SKP_INTERVAL = 1180,
  parameter int unsigned      SKP_CNT_W    = 11,
  parameter logic [SYM_W-1:0] N_FTS        = 8'h20,
  parameter logic [SYM_W-1:0] RATE_ID      = 8'h02
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lane_en,
  tx_symbol_scheduler_if.slave link,
  input  logic [1:0]          ts_sel,
  output logic                ts_sent,
  output logic                skp_sent,
  output logic [SYM_W-1:0]    enc_data,
  output logic                enc_is_kcode,
  output logic                enc_en,
  output logic                enc_rd_prev,
  input  logic                enc_rd_next
);

  logic [1:0]           state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  os_type_e             os_type, os_type_nxt;
  logic [SKP_CNT_W-1:0] skp_cnt, skp_cnt_nxt;
  logic                 rd_seeded;
  tx_sym_t              sym_nxt;
  logic                 ts_sent_nxt, skp_sent_nxt;
  logic                 at_boundary, skp_pending, ts_req, count_sym;
  os_type_e             rom_type;
  logic [IDX_W-1:0]     rom_idx;
  tx_sym_t              rom_sym_c;

  assign at_boundary   = (state == ST_IDLE) || (state == ST_DATA);
  assign skp_pending   = (skp_cnt == SKP_CNT_W'(SKP_INTERVAL - 1));
  assign ts_req        = ts_sel_active(ts_sel);
  assign link.tx_ready = ~rst & lane_en & at_boundary & ~skp_pending & ~ts_req;
  assign enc_rd_prev   = rd_seeded ? enc_rd_next : 1'b0;

  // At a boundary the table is addressed for the set about to start, otherwise for the set in flight
  always_comb begin
    rom_type = os_type;
    rom_idx  = idx;
    if (at_boundary) begin
      rom_idx = '0;
      if (skp_pending)               rom_type = OS_SKP;
      else if (ts_sel == TS_SEL_TS2) rom_type = OS_TS2;
      else                           rom_type = OS_TS1;
    end
  end

  tx_os_rom #(
    .N_FTS   (N_FTS),
    .RATE_ID (RATE_ID)
  ) u_os_rom (
    .os_type (rom_type),
    .idx     (rom_idx),
    .sym_c   (rom_sym_c)
  );

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    os_type_nxt  = os_type;
    skp_cnt_nxt  = skp_cnt;
    sym_nxt      = '{k: 1'b0, data: SYM_IDLE};
    ts_sent_nxt  = 1'b0;
    skp_sent_nxt = 1'b0;
    count_sym    = 1'b0;

    if (!lane_en) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_SKP: begin
          sym_nxt = rom_sym_c;
          if (idx == IDX_W'(SKP_LEN - 1)) begin
            state_nxt    = ST_IDLE;
            idx_nxt      = '0;
            skp_sent_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
        ST_TS: begin
          sym_nxt   = rom_sym_c;
          count_sym = 1'b1;
          if (idx == IDX_W'(TS_LEN - 1)) begin
            state_nxt   = ST_IDLE;
            idx_nxt     = '0;
            ts_sent_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
        default: begin
          // Boundary priority: pending SKP, then training set, then link data, then idle
          if (skp_pending) begin
            sym_nxt     = rom_sym_c;
            state_nxt   = ST_SKP;
            idx_nxt     = IDX_W'(1);
            os_type_nxt = rom_type;
            skp_cnt_nxt = '0;
          end else if (ts_req) begin
            sym_nxt     = rom_sym_c;
            state_nxt   = ST_TS;
            idx_nxt     = IDX_W'(1);
            os_type_nxt = rom_type;
            count_sym   = 1'b1;
          end else if (link.tx_valid) begin
            sym_nxt   = '{k: link.tx_datak, data: link.tx_data};
            state_nxt = ST_DATA;
            count_sym = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            count_sym = 1'b1;
          end
        end
      endcase
      if (count_sym && !skp_pending) skp_cnt_nxt = skp_cnt + SKP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      os_type      <= OS_SKP;
      skp_cnt      <= '0;
      rd_seeded    <= 1'b0;
      enc_data     <= '0;
      enc_is_kcode <= 1'b0;
      enc_en       <= 1'b0;
      ts_sent      <= 1'b0;
      skp_sent     <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      os_type      <= os_type_nxt;
      skp_cnt      <= skp_cnt_nxt;
      rd_seeded    <= rd_seeded | enc_en;
      enc_data     <= sym_nxt.data;
      enc_is_kcode <= sym_nxt.k;
      enc_en       <= lane_en;
      ts_sent      <= ts_sent_nxt;
      skp_sent     <= skp_sent_nxt;
    end
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Scoreboard bench for tx_symbol_scheduler with a short SKP interval and a disparity-only encoder model.
module tb_tx_symbol_scheduler;
  import pcie_phy_pkg::*;

  typedef struct packed {
    logic       k;
    logic [7:0] d;
    logic       ts;
    logic       skp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lane_en = 1'b0;
  logic [1:0] ts_sel = 2'b00;
  logic       ts_sent, skp_sent;
  logic [7:0] enc_data;
  logic       enc_is_kcode, enc_en, enc_rd_prev;
  logic       enc_rd_next;

  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q[$];
  logic       rd_exp = 1'b0;
  logic       prev_en = 1'b0;
  logic       accepted = 1'b0;
  logic [7:0] next_data = 8'h00;

  always #5 clk = ~clk;

  tx_symbol_scheduler_if link_if ();

  tx_symbol_scheduler #(
    .SKP_INTERVAL (8),
    .SKP_CNT_W    (4),
    .N_FTS        (8'h20),
    .RATE_ID      (8'h02)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lane_en      (lane_en),
    .link         (link_if),
    .ts_sel       (ts_sel),
    .ts_sent      (ts_sent),
    .skp_sent     (skp_sent),
    .enc_data     (enc_data),
    .enc_is_kcode (enc_is_kcode),
    .enc_en       (enc_en),
    .enc_rd_prev  (enc_rd_prev),
    .enc_rd_next  (enc_rd_next)
  );

  // 8b/10b disparity: a symbol flips RD when exactly one of its 6b/4b sub-blocks is unbalanced
  function automatic logic rd_flip(input logic k, input logic [7:0] d);
    logic u6, u4;
    case (d[4:0])
      5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16, 5'd23,
      5'd24, 5'd27, 5'd29, 5'd30, 5'd31: u6 = 1'b1;
      5'd28:   u6 = k;
      default: u6 = 1'b0;
    endcase
    u4 = (d[7:5] == 3'd0) || (d[7:5] == 3'd4) || (d[7:5] == 3'd7);
    return u6 ^ u4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)         enc_rd_next <= 1'b0;
    else if (enc_en) enc_rd_next <= enc_rd_prev ^ rd_flip(enc_is_kcode, enc_data);
  end

  function automatic logic [8:0] ts_sym(input int i, input logic [7:0] id);
    case (i)
      0:       return {1'b1, 8'hBC};
      1, 2:    return {1'b1, 8'hF7};
      3:       return {1'b0, 8'h20};
      4:       return {1'b0, 8'h02};
      5:       return {1'b0, 8'h00};
      default: return {1'b0, id};
    endcase
  endfunction

  function automatic void push(input logic k, input logic [7:0] d, input logic ts, input logic skp);
    exp_t e;
    e = '{k: k, d: d, ts: ts, skp: skp};
    exp_q.push_back(e);
  endfunction

  // Monitor: every enc_en cycle consumes one expected symbol and checks disparity sequencing
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_exp = 1'b0;
      end else if (enc_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_symbol: got k=%0b data=%02h with empty scoreboard", enc_is_kcode, enc_data);
        end else begin
          e = exp_q.pop_front();
          if ({enc_is_kcode, enc_data, ts_sent, skp_sent} !== {e.k, e.d, e.ts, e.skp}) begin
            failures++;
            $display("FAIL symbol: got k=%0b data=%02h ts_sent=%0b skp_sent=%0b, want k=%0b data=%02h ts_sent=%0b skp_sent=%0b",
                     enc_is_kcode, enc_data, ts_sent, skp_sent, e.k, e.d, e.ts, e.skp);
          end
          checks++;
          if (enc_rd_prev !== rd_exp) begin
            failures++;
            $display("FAIL rd_prev: got %0b want %0b (symbol %02h)", enc_rd_prev, rd_exp, e.d);
          end
          rd_exp = rd_exp ^ rd_flip(e.k, e.d);
        end
      end
    end
  end

  // One decision cycle: drive inputs on the falling edge, check enc_en and tx_ready
  task automatic step(input logic en, input logic vld, input logic [1:0] ts, input logic exp_rdy);
    @(negedge clk);
    if (accepted) next_data = next_data + 8'd1;
    checks++;
    if (enc_en !== prev_en) begin
      failures++;
      $display("FAIL enc_en: got %0b want %0b", enc_en, prev_en);
    end
    lane_en          = en;
    link_if.tx_valid = vld;
    link_if.tx_data  = next_data;
    link_if.tx_datak = 1'b0;
    ts_sel           = ts;
    #1;
    checks++;
    if (link_if.tx_ready !== exp_rdy) begin
      failures++;
      $display("FAIL tx_ready: got %0b want %0b (data %02h)", link_if.tx_ready, exp_rdy, next_data);
    end
    accepted = vld & link_if.tx_ready;
    prev_en  = en;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({link_if.tx_ready, enc_en, enc_data, enc_is_kcode, ts_sent, skp_sent, enc_rd_prev} !== 14'd0) begin
      failures++;
      $display("FAIL %s: got ready=%0b en=%0b data=%02h k=%0b ts=%0b skp=%0b rd=%0b, want all 0", name,
               link_if.tx_ready, enc_en, enc_data, enc_is_kcode, ts_sent, skp_sent, enc_rd_prev);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lane_en = 1'b0;
    link_if.tx_valid = 1'b0;
    ts_sel = 2'b00;
    accepted = 1'b0;
    prev_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    lane_en = 1'b1;
    link_if.tx_valid = 1'b1;
    ts_sel = 2'b00;
    #1;
    check_reset_outputs("reset_state");
    exp_q.delete();
    release_reset();
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d expected symbols never appeared, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic skp_set(input logic vld, input logic [1:0] ts);
    step(1'b1, vld, ts, 1'b0); push(1'b1, 8'hBC, 1'b0, 1'b0);
    step(1'b1, vld, ts, 1'b0); push(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b1, vld, ts, 1'b0); push(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b1, vld, ts, 1'b0); push(1'b1, 8'h1C, 1'b0, 1'b1);
  endtask

  initial begin
    logic [8:0] s;
    link_if.tx_data  = 8'h00;
    link_if.tx_datak = 1'b0;
    link_if.tx_valid = 1'b0;

    // Data stream interrupted by SKP after seven symbols
    do_reset();
    next_data = 8'h01;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 2'b00, 1'b1); push(1'b0, 8'(8'h01 + i), 1'b0, 1'b0);
    end
    skp_set(1'b1, 2'b00);
    step(1'b1, 1'b1, 2'b00, 1'b1); push(1'b0, 8'h08, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b0);
    drain("skp");

    // One TS1 set, SKP pending meanwhile, data held off until both finish
    do_reset();
    next_data = 8'h80;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, (i == 0) ? 2'b01 : 2'b00, 1'b0);
      s = ts_sym(i, 8'h4A); push(s[8], s[7:0], i == 15, 1'b0);
    end
    skp_set(1'b1, 2'b00);
    step(1'b1, 1'b1, 2'b00, 1'b1); push(1'b0, 8'h80, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b0);
    drain("ts1");

    // ts_sel changes mid-set: current set stays TS1, next set is TS2
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, (i < 7) ? 2'b01 : 2'b10, 1'b0);
      s = ts_sym(i, 8'h4A); push(s[8], s[7:0], i == 15, 1'b0);
    end
    skp_set(1'b0, 2'b10);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, (i == 0) ? 2'b10 : 2'b00, 1'b0);
      s = ts_sym(i, 8'h45); push(s[8], s[7:0], i == 15, 1'b0);
    end
    skp_set(1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00, 1'b0);
    drain("ts_switch");

    // lane_en drop aborts the set; async reset mid-SKP clears everything
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 2'b01, 1'b0);
      s = ts_sym(i, 8'h4A); push(s[8], s[7:0], 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 2'b01, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 2'b01, 1'b0);
      s = ts_sym(i, 8'h4A); push(s[8], s[7:0], i == 15, 1'b0);
    end
    step(1'b1, 1'b0, 2'b01, 1'b0); push(1'b1, 8'hBC, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b01, 1'b0); push(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b01, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_skp_reset");
    exp_q.delete();
    release_reset();
    next_data = 8'h55;
    step(1'b1, 1'b1, 2'b00, 1'b1); push(1'b0, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b0);
    drain("abort");

    // All 256 D-codes through the disparity loop, SKP every seven data symbols
    do_reset();
    next_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 2'b00, 1'b1); push(1'b0, 8'(i), 1'b0, 1'b0);
      if (i % 7 == 6) skp_set(1'b1, 2'b00);
    end
    step(1'b0, 1'b0, 2'b00, 1'b0);
    drain("rd_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
